// File: rtl/frankie_mem_pkg.sv
// Shared types and constants for the Frankie data-memory arbiter.
package frankie_mem_pkg;

    localparam int FRANKIE_ADDR_W = 16;
    localparam int FRANKIE_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_IO   = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if
    import frankie_mem_pkg::*;
#(
    parameter int ADDR_W = FRANKIE_ADDR_W,
    parameter int DATA_W = FRANKIE_DATA_W
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        gnt_id;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, io_rdata, io_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, gnt_id, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, io_rdata, io_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, gnt_id, busy
    );
endinterface

// File: rtl/arb_wait_counter.sv
// Loadable down-counter timing the ACCESS phase; last_cycle flags the final ACCESS cycle.
module arb_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       last_cycle
);
    logic [3:0] cnt_r;

    // Load on grant, then count down to zero while the access is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last_cycle = (cnt_r == 4'd0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data memory between CPU and I/O with a fixed-latency FSM.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import frankie_mem_pkg::*;
#(
    parameter int ADDR_W       = FRANKIE_ADDR_W,
    parameter int DATA_W       = FRANKIE_DATA_W,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                CLK,
    input  logic                Reset_n,
    mem_port_arbiter_if.slave   bus
);
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_t        state_r;
    logic              cpu_ack_r;
    logic              io_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] io_rdata_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [1:0]        gnt_id_r;
    logic              grant_cpu_s;
    logic              grant_io_s;
    logic              starved_s;
    logic              last_cycle_s;
    logic              cnt_load_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt_r;

    assign starved_s = (starve_cnt_r == SW'(STARVE_LIMIT));

    // Count CPU grants that bypassed a pending I/O request; an I/O grant clears it.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt_r <= '0;
        end else if ((state_r == IDLE) && grant_io_s) begin
            starve_cnt_r <= '0;
        end else if ((state_r == IDLE) && grant_cpu_s && bus.io_req && !starved_s) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign starved_s = 1'b0;
`endif

    // Fixed CPU priority, overridden only when the guard reports I/O starvation.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_io_s  = 1'b0;
        if (bus.io_req && (starved_s || !bus.cpu_req)) begin
            grant_io_s = 1'b1;
        end else if (bus.cpu_req) begin
            grant_cpu_s = 1'b1;
        end else begin
            grant_cpu_s = 1'b0;
        end
    end

    assign cnt_load_s = (state_r == IDLE) && (grant_cpu_s || grant_io_s);

    arb_wait_counter u_wait (
        .clk        (CLK),
        .rst_n      (Reset_n),
        .load       (cnt_load_s),
        .load_val   (4'(MEM_LATENCY - 1)),
        .en         (state_r == ACCESS),
        .last_cycle (last_cycle_s)
    );

    // Main sequencer: grant in IDLE, hold the memory bus for ACCESS, pulse ack in RESP.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            cpu_ack_r   <= 1'b0;
            io_ack_r    <= 1'b0;
            cpu_rdata_r <= '0;
            io_rdata_r  <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            gnt_id_r    <= GNT_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_ack_r <= 1'b0;
                    io_ack_r  <= 1'b0;
                    if (grant_io_s) begin
                        state_r     <= ACCESS;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= bus.io_we;
                        mem_addr_r  <= bus.io_addr;
                        mem_wdata_r <= bus.io_wdata;
                        gnt_id_r    <= GNT_IO;
                    end else if (grant_cpu_s) begin
                        state_r     <= ACCESS;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= bus.cpu_we;
                        mem_addr_r  <= bus.cpu_addr;
                        mem_wdata_r <= bus.cpu_wdata;
                        gnt_id_r    <= GNT_CPU;
                    end else begin
                        gnt_id_r <= GNT_NONE;
                    end
                end
                ACCESS: begin
                    if (last_cycle_s) begin
                        state_r   <= RESP;
                        mem_en_r  <= 1'b0;
                        mem_we_r  <= 1'b0;
                        cpu_ack_r <= (gnt_id_r == GNT_CPU);
                        io_ack_r  <= (gnt_id_r == GNT_IO);
                        if (!mem_we_r && (gnt_id_r == GNT_CPU)) begin
                            cpu_rdata_r <= bus.mem_rdata;
                        end else if (!mem_we_r && (gnt_id_r == GNT_IO)) begin
                            io_rdata_r <= bus.mem_rdata;
                        end else begin
                            cpu_rdata_r <= cpu_rdata_r;
                        end
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                RESP: begin
                    state_r   <= IDLE;
                    cpu_ack_r <= 1'b0;
                    io_ack_r  <= 1'b0;
                    gnt_id_r  <= GNT_NONE;
                end
                default: begin
                    state_r   <= IDLE;
                    cpu_ack_r <= 1'b0;
                    io_ack_r  <= 1'b0;
                    mem_en_r  <= 1'b0;
                    mem_we_r  <= 1'b0;
                    gnt_id_r  <= GNT_NONE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.io_ack    = io_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.io_rdata  = io_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.busy      = (state_r != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (latency 2 instance plus a latency 1 instance).
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [15:0] mem [0:1023];
    logic [15:0] exp_rd [0:2];
    logic [15:0] adr    [0:2];

    mem_port_arbiter_if bus  ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata  = mem[bus.mem_addr[9:0]];
    assign bus1.mem_rdata = mem[bus1.mem_addr[9:0]];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h010] = 16'hBEEF;
        mem[10'h020] = 16'hCAFE;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
        bus.io_req  = 1'b0; bus.io_we  = 1'b0; bus.io_addr  = 16'h0000; bus.io_wdata  = 16'h0000;
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0000; bus1.cpu_wdata = 16'h0000;
        bus1.io_req  = 1'b0; bus1.io_we  = 1'b0; bus1.io_addr  = 16'h0000; bus1.io_wdata  = 16'h0000;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_gnt", {30'd0, bus.gnt_id}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_acks", {30'd0, bus.cpu_ack, bus.io_ack}, 32'd0);
        check("rst_rdata", {bus.cpu_rdata, bus.io_rdata}, 32'd0);

        // 1: CPU read of 0x0010, ack on cycle 3
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        step();
        check("t1_c1_gnt", {30'd0, bus.gnt_id}, 32'd1);
        check("t1_c1_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd2);
        check("t1_c1_ack", {31'd0, bus.cpu_ack}, 32'd0);
        step();
        check("t1_c2_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd2);
        check("t1_c2_ack", {31'd0, bus.cpu_ack}, 32'd0);
        step();
        check("t1_c3_ack", {31'd0, bus.cpu_ack}, 32'd1);
        check("t1_rdata", {16'd0, bus.cpu_rdata}, 32'h0000BEEF);
        check("t1_c3_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
        check("t1_c3_gnt", {30'd0, bus.gnt_id}, 32'd1);
        bus.cpu_req = 1'b0;
        step();
        check("t1_c4_ack", {31'd0, bus.cpu_ack}, 32'd0);
        check("t1_c4_idle", {29'd0, bus.gnt_id, bus.busy}, 32'd0);

        // 2: IO write 0x1234 to 0x0200
        bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 16'h0200; bus.io_wdata = 16'h1234;
        step();
        check("t2_gnt", {30'd0, bus.gnt_id}, 32'd2);
        check("t2_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd3);
        step(); step();
        check("t2_acks", {30'd0, bus.cpu_ack, bus.io_ack}, 32'd1);
        check("t2_io_rdata", {16'd0, bus.io_rdata}, 32'd0);
        check("t2_mem", {16'd0, mem[10'h200]}, 32'h00001234);
        bus.io_req = 1'b0; bus.io_we = 1'b0;
        step();

        // 3: simultaneous requests, CPU first then I/O
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
        bus.io_req  = 1'b1; bus.io_addr  = 16'h0200;
        step();
        check("t3_first_gnt", {30'd0, bus.gnt_id}, 32'd1);
        step(); step();
        check("t3_cpu_acks", {30'd0, bus.cpu_ack, bus.io_ack}, 32'd2);
        check("t3_cpu_rdata", {16'd0, bus.cpu_rdata}, 32'h0000CAFE);
        bus.cpu_req = 1'b0;
        step();
        check("t3_idle_gnt", {30'd0, bus.gnt_id}, 32'd0);
        step();
        check("t3_second_gnt", {30'd0, bus.gnt_id}, 32'd2);
        step(); step();
        check("t3_io_acks", {30'd0, bus.cpu_ack, bus.io_ack}, 32'd1);
        check("t3_io_rdata", {16'd0, bus.io_rdata}, 32'h00001234);
        bus.io_req = 1'b0;
        step();

        // 4: continuous contention
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        bus.io_req  = 1'b1; bus.io_addr  = 16'h0020;
        for (int k = 0; k < 6; k++) begin
            step();
`ifdef ARB_STARVE_GUARD_EN
            check($sformatf("t4_arb%0d_gnt", k), {30'd0, bus.gnt_id}, (k == 4) ? 32'd2 : 32'd1);
            if (k == 4) check("t4_starve_clr", 32'(u_dut.starve_cnt_r), 32'd0);
`else
            check($sformatf("t4_arb%0d_gnt", k), {30'd0, bus.gnt_id}, 32'd1);
`endif
            step(); step(); step();
        end
        bus.cpu_req = 1'b0; bus.io_req = 1'b0;
        step();

        // 5: async reset mid-ACCESS
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0200;
        step();
        check("t5_pre_en", {31'd0, bus.mem_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_en", {31'd0, bus.mem_en}, 32'd0);
        check("t5_rst_gnt", {30'd0, bus.gnt_id}, 32'd0);
        check("t5_rst_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
        bus.cpu_req = 1'b0;
        step();
        check("t5_no_ack", {30'd0, bus.cpu_ack, bus.io_ack}, 32'd0);
        rst_n = 1'b1;
        step();
        bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_addr = 16'h0010;
        step();
        check("t5_post_gnt", {30'd0, bus.gnt_id}, 32'd2);
        step(); step();
        check("t5_post_ack", {31'd0, bus.io_ack}, 32'd1);
        check("t5_post_rdata", {16'd0, bus.io_rdata}, 32'h0000BEEF);
        bus.io_req = 1'b0;
        step();

        // 6: latency 1, back-to-back CPU reads, ack every 3 cycles
        adr[0] = 16'h0010; exp_rd[0] = 16'hBEEF;
        adr[1] = 16'h0200; exp_rd[1] = 16'h1234;
        adr[2] = 16'h0020; exp_rd[2] = 16'hCAFE;
        bus1.cpu_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus1.cpu_addr = adr[k];
            step();
            check($sformatf("t6_r%0d_access_ack", k), {31'd0, bus1.cpu_ack}, 32'd0);
            check($sformatf("t6_r%0d_en", k), {31'd0, bus1.mem_en}, 32'd1);
            step();
            check($sformatf("t6_r%0d_ack", k), {31'd0, bus1.cpu_ack}, 32'd1);
            check($sformatf("t6_r%0d_rdata", k), {16'd0, bus1.cpu_rdata}, {16'd0, exp_rd[k]});
            if (k == 2) bus1.cpu_req = 1'b0;
            step();
            check($sformatf("t6_r%0d_idle_ack", k), {31'd0, bus1.cpu_ack}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
